hazard_stall_unit: RTL and testbench



---
 rtl/hazard_stall_unit.sv | 133 +++++++++++++
 tb/tb_hazard_stall_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: pipeline stall/flush sequencer for a 5-stage core.
// Arbitrates memory wait, branch redirect and load-use hazards into the
// PC / IF-ID / ID-EX control signals, and keeps stall statistics.
//
// state   | meaning
// --------+---------------------------------------------------------
// RUN     | normal issue; evaluates mem_stall > redirect > load_use
// MEMWAIT | data memory busy, whole pipe frozen until mem_ready
// FLUSH   | second cycle of a redirect flush (IF/ID and ID/EX squashed)
// ILLEGAL | unreachable encoding; treated as RUN
module hazard_stall_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  id_op,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_wreg,
  input  logic        redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        ctrl_enable,
  output logic        pipe_hold,
  output logic [15:0] stall_count,
  output logic        mem_timeout,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MEMWAIT = 2'b01,
    ST_FLUSH   = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  state_t     cur_st;
  state_t     nxt_st;
  logic       enter_wait;
  logic [7:0] wait_cnt;
  logic       rt_used;
  logic       load_use;
  logic       mem_stall;

  assign state = cur_st;

  // Only R-type, SW and BEQ actually read rt as a source operand.
  assign rt_used   = (id_op == 6'b000000) || (id_op == 6'b101011) || (id_op == 6'b000100);
  assign load_use  = ex_memread && (ex_wreg != 5'd0) &&
                     ((ex_wreg == id_rs) || (rt_used && (ex_wreg == id_rt)));
  assign mem_stall = mem_req && !mem_ready;

  // State register; reset also covers recovery from the illegal encoding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_st <= ST_RUN;
    else     cur_st <= nxt_st;
  end

  // Next state and pipeline controls; defaults are normal issue in RUN.
  always_comb begin
    nxt_st      = ST_RUN;
    enter_wait  = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    ctrl_enable = 1'b1;
    pipe_hold   = 1'b0;
    case (cur_st)
      ST_MEMWAIT: begin
        if (!mem_ready) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          nxt_st     = ST_MEMWAIT;
        end
      end
      ST_FLUSH: begin
        // A memory stall here wins and the pending flush is dropped.
        if (mem_stall) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          enter_wait = 1'b1;
          nxt_st     = ST_MEMWAIT;
        end else begin
          ifid_flush  = 1'b1;
          ctrl_enable = 1'b0;
        end
      end
      default: begin
        if (mem_stall) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          enter_wait = 1'b1;
          nxt_st     = ST_MEMWAIT;
        end else if (redirect) begin
          ifid_flush  = 1'b1;
          ctrl_enable = 1'b0;
          nxt_st      = ST_FLUSH;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          ctrl_enable = 1'b0;
        end
      end
    endcase
  end

  // Memory wait counter: restarts on every entry, saturates at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           wait_cnt <= 8'd0;
    else if (enter_wait)                               wait_cnt <= 8'd0;
    else if (cur_st == ST_MEMWAIT && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
  end

  // Sticky timeout, raised on the same edge the counter reaches 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            mem_timeout <= 1'b0;
    else if (cur_st == ST_MEMWAIT && wait_cnt == 8'hFE) mem_timeout <= 1'b1;
  end

  // Saturating count of every cycle that is not a normal issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= 16'd0;
    else if ((!pc_write || !ctrl_enable) && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: single-cycle vector table from RUN,
// followed by hand-written multi-cycle sequences.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, ex_wreg;
  logic        ex_memread, redirect, mem_req, mem_ready;
  logic        pc_write, ifid_write, ifid_flush, ctrl_enable, pipe_hold;
  logic [15:0] stall_count;
  logic        mem_timeout;
  logic [1:0]  state;

  int n_total = 0;
  int n_pass  = 0;

  // Output bundle order: pc_write, ifid_write, ifid_flush, ctrl_enable, pipe_hold
  localparam logic [4:0] O_RUN  = 5'b11010;
  localparam logic [4:0] O_BUB  = 5'b00000;
  localparam logic [4:0] O_FLU  = 5'b11100;
  localparam logic [4:0] O_HOLD = 5'b00011;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_wreg(ex_wreg), .redirect(redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .ctrl_enable(ctrl_enable),
    .pipe_hold(pipe_hold), .stall_count(stall_count), .mem_timeout(mem_timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       mr;
    logic [4:0] wr;
    logic       rd, mq, my;
    logic [4:0] eo;
    logic [1:0] es;
    logic [15:0] ec;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic clr_inputs();
    id_op = 6'd0; id_rs = 5'd0; id_rt = 5'd0; ex_memread = 1'b0; ex_wreg = 5'd0;
    redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu();
    id_op = 6'b000000; id_rs = 5'd1; id_rt = 5'd5; ex_memread = 1'b1; ex_wreg = 5'd5;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Check outputs mid-cycle, then state just after the next rising edge.
  task automatic step(input string nm, input logic [4:0] eo, input logic [1:0] es);
    @(negedge clk);
    chk({nm, "_out"}, {27'd0, pc_write, ifid_write, ifid_flush, ctrl_enable, pipe_hold}, {27'd0, eo});
    @(posedge clk); #1;
    chk({nm, "_state"}, {30'd0, state}, {30'd0, es});
  endtask

  initial begin
    vt[0]  = '{"idle",        6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN,  2'b00, 16'd0};
    vt[1]  = '{"lu_rtype_rt", 6'h00, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_BUB,  2'b00, 16'd1};
    vt[2]  = '{"ori_rt_nohz", 6'h0D, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_RUN,  2'b00, 16'd0};
    vt[3]  = '{"wreg_zero",   6'h00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN,  2'b00, 16'd0};
    vt[4]  = '{"ori_rs_hz",   6'h0D, 5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_BUB,  2'b00, 16'd1};
    vt[5]  = '{"sw_rt_hz",    6'h2B, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, O_BUB,  2'b00, 16'd1};
    vt[6]  = '{"beq_rt_hz",   6'h04, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, O_BUB,  2'b00, 16'd1};
    vt[7]  = '{"lw_rt_nohz",  6'h23, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, O_RUN,  2'b00, 16'd0};
    vt[8]  = '{"no_memread",  6'h00, 5'd4, 5'd4, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, O_RUN,  2'b00, 16'd0};
    vt[9]  = '{"redirect",    6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_FLU,  2'b10, 16'd1};
    vt[10] = '{"redir_lu",    6'h00, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_FLU,  2'b10, 16'd1};
    vt[11] = '{"mem_stall",   6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_HOLD, 2'b01, 16'd1};
    vt[12] = '{"mem_done",    6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_RUN,  2'b00, 16'd0};
    vt[13] = '{"noreq",       6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN,  2'b00, 16'd0};
    vt[14] = '{"all_three",   6'h00, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, O_HOLD, 2'b01, 16'd1};
    vt[15] = '{"rdy_noreq_lu",6'h00, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, O_BUB,  2'b00, 16'd1};

    clr_inputs();
    rst = 1'b1;
    #2;
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_cnt", {16'd0, stall_count}, 32'd0);
    chk("reset_tmo", {31'd0, mem_timeout}, 32'd0);
    // Reset with a load-use present: RUN outputs, but counter stays cleared.
    set_lu();
    @(negedge clk);
    chk("rst_lu_out", {27'd0, pc_write, ifid_write, ifid_flush, ctrl_enable, pipe_hold}, {27'd0, O_BUB});
    @(posedge clk); #1;
    chk("rst_lu_cnt", {16'd0, stall_count}, 32'd0);
    rst = 1'b0;
    clr_inputs();

    for (int i = 0; i < 16; i++) begin
      do_reset();
      id_op = vt[i].op; id_rs = vt[i].rs; id_rt = vt[i].rt; ex_memread = vt[i].mr;
      ex_wreg = vt[i].wr; redirect = vt[i].rd; mem_req = vt[i].mq; mem_ready = vt[i].my;
      step(vt[i].nm, vt[i].eo, vt[i].es);
      chk({vt[i].nm, "_cnt"}, {16'd0, stall_count}, {16'd0, vt[i].ec});
      clr_inputs();
    end

    // Load-use lasts exactly one bubble, then the bubble clears the hazard.
    do_reset();
    set_lu();
    step("lu_seq0", O_BUB, 2'b00);
    clr_inputs();
    step("lu_seq1", O_RUN, 2'b00);
    chk("lu_seq_cnt", {16'd0, stall_count}, 32'd1);

    // Memory wait of four cycles.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("mw_hold", O_HOLD, 2'b01);
    mem_ready = 1'b1;
    step("mw_done", O_RUN, 2'b00);
    chk("mw_cnt", {16'd0, stall_count}, 32'd4);
    clr_inputs();

    // Redirect pulse: two flush cycles, PC never frozen.
    do_reset();
    redirect = 1'b1;
    step("rd_run", O_FLU, 2'b10);
    redirect = 1'b0;
    step("rd_flush", O_FLU, 2'b00);
    step("rd_after", O_RUN, 2'b00);
    chk("rd_cnt", {16'd0, stall_count}, 32'd2);

    // All three events together: memory first, then the flush.
    do_reset();
    set_lu(); redirect = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    step("sim_ent", O_HOLD, 2'b01);
    step("sim_wait", O_HOLD, 2'b01);
    mem_ready = 1'b1;
    step("sim_rdy", O_RUN, 2'b00);
    mem_req = 1'b0; mem_ready = 1'b0;
    step("sim_redir", O_FLU, 2'b10);
    redirect = 1'b0;
    step("sim_flush_ign_lu", O_FLU, 2'b00);
    clr_inputs();
    step("sim_idle", O_RUN, 2'b00);
    chk("sim_cnt", {16'd0, stall_count}, 32'd4);

    // Memory stall arriving in FLUSH discards the flush.
    do_reset();
    redirect = 1'b1;
    step("fm_run", O_FLU, 2'b10);
    redirect = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
    step("fm_flush_ms", O_HOLD, 2'b01);
    mem_ready = 1'b1;
    step("fm_done", O_RUN, 2'b00);
    chk("fm_cnt", {16'd0, stall_count}, 32'd2);
    clr_inputs();

    // Asynchronous reset in the middle of FLUSH.
    do_reset();
    redirect = 1'b1;
    step("rf_run", O_FLU, 2'b10);
    redirect = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rf_state", {30'd0, state}, 32'd0);
    chk("rf_cnt", {16'd0, stall_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Timeout: 255 MEMWAIT cycles raise the sticky flag.
    mem_req = 1'b1; mem_ready = 1'b0;
    step("to_ent", O_HOLD, 2'b01);
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 255) chk("to_early", {31'd0, mem_timeout}, 32'd0);
      @(posedge clk); #1;
      if (i == 255) chk("to_set", {31'd0, mem_timeout}, 32'd1);
    end
    chk("to_sticky", {31'd0, mem_timeout}, 32'd1);
    chk("to_state", {30'd0, state}, 32'd1);
    chk("to_cnt", {16'd0, stall_count}, 32'd301);
    #2 rst = 1'b1;
    #1;
    chk("to_rst_state", {30'd0, state}, 32'd0);
    chk("to_rst_tmo", {31'd0, mem_timeout}, 32'd0);
    chk("to_rst_cnt", {16'd0, stall_count}, 32'd0);
    @(posedge clk); #1;
    clr_inputs();
    rst = 1'b0;
    step("post_rst", O_RUN, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
